data_mem_responder: RTL

Responder end of the CPU data-memory bus: accepts one read or write dispatch at a time from the pipeline, holds `busy` for a fixed access latency, and then returns lane-aligned read data or commits byte-enabled write data. It sits between the CPU's execute/writeback stages and the on-chip data RAM. It owns all sub-word lane steering and alignment checking, so the CPU only sign-extends.

---
 rtl/data_mem_responder_pkg.sv | 51 +++++
 rtl/data_mem_responder_if.sv | 23 ++
 rtl/data_mem_responder_bram_be_sp.sv | 32 +++
 rtl/data_mem_responder.sv | 130 +++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared types and lane-steering helpers for the data-memory responder.
// Kept small so the CPU side can reuse width_t when it builds dispatches.
package mem;

  typedef enum logic [1:0] {
    BYTE  = 2'd0,
    WORD  = 2'd1,
    DWORD = 2'd2
  } width_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } resp_state_t;

  typedef struct packed {
    logic        is_write;
    width_t      width;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  function automatic logic is_aligned(width_t w, logic [1:0] o);
    case (w)
      BYTE:    return 1'b1;
      WORD:    return !o[0];
      DWORD:   return o == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(width_t w, logic [1:0] o);
    case (w)
      BYTE:    return 4'b0001 << o;
      WORD:    return o[1] ? 4'b1100 : 4'b0011;
      DWORD:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Replicate store data across every lane; the byte enables pick the live ones.
  function automatic logic [31:0] lane_wdata(width_t w, logic [31:0] d);
    case (w)
      BYTE:    return {4{d[7:0]}};
      WORD:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// CPU <-> data-memory responder bus: dispatch side from the pipeline,
// status and load result back from the responder.
interface data_mem_responder_if;
  logic         dispatch_read;
  logic         dispatch_write;
  logic [31:0]  addr;
  mem::width_t  mem_width;
  logic [31:0]  write_data;
  logic         busy;
  logic [31:0]  read_data;
  logic         misalign_err;
  logic         proto_err;

  modport master (
    output dispatch_read, dispatch_write, addr, mem_width, write_data,
    input  busy, read_data, misalign_err, proto_err
  );

  modport slave (
    input  dispatch_read, dispatch_write, addr, mem_width, write_data,
    output busy, read_data, misalign_err, proto_err
  );
endinterface

// File: rtl/data_mem_responder_bram_be_sp.sv
// Single-port 32-bit RAM with four byte enables and a registered read port.
// Read and write share one address; a read in the same cycle as a write returns the old word.
module bram_be_sp #(
  parameter int    DEPTH     = 4096,
  parameter string INIT_FILE = ""
) (
  input  logic                     clk_i,
  input  logic                     en_i,
  input  logic                     we_i,
  input  logic [3:0]               be_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [31:0]              wdata_i,
  output logic [31:0]              rdata_o
);

  logic [31:0] ram_q [DEPTH];
  logic [31:0] rdata_q;

  // NOTE: the array and read register have no reset so the tools map them onto block RAM;
  // contents survive a responder reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) ram_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    if (en_i) rdata_q <= ram_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one access at a time, fixed busy latency, lane steering
// and alignment checking so the CPU only has to sign-extend loads.
module data_mem_responder
  import mem::*;
#(
  parameter int    DEPTH     = 4096,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = ""
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  data_mem_responder_if.slave  bus
);

  localparam int            AW       = $clog2(DEPTH);
  localparam int            CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  resp_state_t   state_q;
  req_t          req_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic          misalign_q;
  logic          proto_q;
  logic [31:0]   read_data_q;

  logic          one_dispatch;
  logic          both_dispatch;
  logic          req_aligned;
  logic          first_wait;
  logic          last_wait;
  logic          done_read;
  logic          ram_en;
  logic          ram_we;
  logic [31:0]   ram_rdata;
  logic [31:0]   lane_rdata;
  logic [31:0]   rd_shifted;
  logic          unused_addr_hi;

  assign one_dispatch  = bus.dispatch_read ^ bus.dispatch_write;
  assign both_dispatch = bus.dispatch_read & bus.dispatch_write;
  assign req_aligned   = is_aligned(req_q.width, req_q.addr[1:0]);
  assign first_wait    = (state_q == WAIT) && (cnt_q == CNT_LOAD);
  assign last_wait     = (state_q == WAIT) && (cnt_q == '0);
  assign done_read     = (state_q == DONE) && !req_q.is_write;
  assign unused_addr_hi = ^req_q.addr[31:AW+2];

  // Reset must win even on the commit cycle, so the RAM strobes are gated by it directly.
  assign ram_en = rst_n_in && first_wait && !req_q.is_write;
  assign ram_we = rst_n_in && last_wait && req_q.is_write && req_aligned;

  bram_be_sp #(
    .DEPTH     (DEPTH),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk_i   (clk_in),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .be_i    (lane_be(req_q.width, req_q.addr[1:0])),
    .addr_i  (req_q.addr[AW+1:2]),
    .wdata_i (lane_wdata(req_q.width, req_q.wdata)),
    .rdata_o (ram_rdata)
  );

  assign rd_shifted = ram_rdata >> {req_q.addr[1:0], 3'b000};

  // NOTE: lane_rdata gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    lane_rdata = 32'h0;
    if (req_aligned) begin
      case (req_q.width)
        BYTE:    lane_rdata = {24'h0, rd_shifted[7:0]};
        WORD:    lane_rdata = {16'h0, rd_shifted[15:0]};
        DWORD:   lane_rdata = ram_rdata;
        default: lane_rdata = 32'h0;
      endcase
    end
  end

  // NOTE: all state here is updated with <= so every branch sees the pre-edge values.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q     <= IDLE;
      req_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      misalign_q  <= 1'b0;
      proto_q     <= 1'b0;
      read_data_q <= 32'h0;
    end else begin
      misalign_q <= 1'b0;
      proto_q    <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (done_read) read_data_q <= lane_rdata;
          state_q <= IDLE;
          busy_q  <= 1'b0;
          if (one_dispatch) begin
            state_q        <= WAIT;
            busy_q         <= 1'b1;
            cnt_q          <= CNT_LOAD;
            req_q.is_write <= bus.dispatch_write;
            req_q.width    <= bus.mem_width;
            req_q.addr     <= bus.addr;
            req_q.wdata    <= bus.write_data;
          end else if (both_dispatch) begin
            proto_q <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q    <= DONE;
            busy_q     <= 1'b0;
            misalign_q <= !req_aligned;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // In DONE of a read the steered RAM word is presented directly; afterwards it is held.
  assign bus.read_data    = done_read ? lane_rdata : read_data_q;
  assign bus.busy         = busy_q;
  assign bus.misalign_err = misalign_q;
  assign bus.proto_err    = proto_q;

endmodule
